// File: rtl/unified_mem_arbiter.sv
// Arbiter that lets the I-cache and D-cache miss ports share one block-level main memory.
// Ties alternate on the last grant; each transaction is IDLE -> ACCESS -> RESPOND.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  INSTR_READ,
  input  logic [ADDR_WIDTH-1:0] INSTR_ADDR,
  output logic [DATA_WIDTH-1:0] INSTR_READDATA,
  output logic                  INSTR_BUSYWAIT,
  input  logic                  DATA_READ,
  input  logic                  DATA_WRITE,
  input  logic [ADDR_WIDTH-1:0] DATA_ADDR,
  input  logic [DATA_WIDTH-1:0] DATA_WRITEDATA,
  output logic [DATA_WIDTH-1:0] DATA_READDATA,
  output logic                  DATA_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESPOND = 2'd2} state_t;
  typedef enum logic {G_INSTR = 1'b0, G_DATA = 1'b1} req_t;

  state_t state, state_next;
  req_t   grant, grant_next, last, last_next, pick;
  logic   first_q, first_next;
  logic   mem_read_next, mem_write_next;
  logic   instr_req, data_req;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_next, instr_rdata_next, data_rdata_next;

  assign instr_req = INSTR_READ;
  assign data_req  = DATA_READ | DATA_WRITE;

  // Handshake: a requester holds its request until its busywait drops; busywait is low
  // for exactly the RESPOND cycle, and the request must be dropped or changed by the
  // edge that ends RESPOND. A requester that is not granted sees busywait held high.
  assign INSTR_BUSYWAIT = instr_req & ~((state == S_RESPOND) && (grant == G_INSTR));
  assign DATA_BUSYWAIT  = data_req  & ~((state == S_RESPOND) && (grant == G_DATA));

  always_comb begin
    state_next       = state;
    grant_next       = grant;
    last_next        = last;
    first_next       = first_q;
    pick             = G_INSTR;
    mem_read_next    = MEM_READ;
    mem_write_next   = MEM_WRITE;
    mem_addr_next    = MEM_ADDR;
    mem_wdata_next   = MEM_WRITEDATA;
    instr_rdata_next = INSTR_READDATA;
    data_rdata_next  = DATA_READDATA;
    case (state)
      S_IDLE: begin
        if (instr_req || data_req) begin
          if (instr_req && data_req) pick = (last == G_INSTR) ? G_DATA : G_INSTR;
          else                       pick = data_req ? G_DATA : G_INSTR;
          grant_next = pick;
          last_next  = pick;
          first_next = 1'b1;
          state_next = S_ACCESS;
          if (pick == G_DATA) begin
            mem_addr_next  = DATA_ADDR;
            mem_wdata_next = DATA_WRITEDATA;
            mem_write_next = DATA_WRITE;
            mem_read_next  = ~DATA_WRITE;
          end else begin
            mem_addr_next  = INSTR_ADDR;
            mem_read_next  = 1'b1;
            mem_write_next = 1'b0;
          end
        end
      end
      S_ACCESS: begin
        first_next = 1'b0;
        // The first ACCESS edge is skipped so a memory that raises busywait late is not missed.
        if (!first_q && !MEM_BUSYWAIT) begin
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
          state_next     = S_RESPOND;
          if (MEM_READ) begin
            if (grant == G_INSTR && instr_req)    instr_rdata_next = MEM_READDATA;
            else if (grant == G_DATA && data_req) data_rdata_next  = MEM_READDATA;
          end
        end
      end
      S_RESPOND: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= S_IDLE;
      grant          <= G_INSTR;
      last           <= G_INSTR;
      first_q        <= 1'b0;
      MEM_READ       <= 1'b0;
      MEM_WRITE      <= 1'b0;
      MEM_ADDR       <= '0;
      MEM_WRITEDATA  <= '0;
      INSTR_READDATA <= '0;
      DATA_READDATA  <= '0;
    end else begin
      state          <= state_next;
      grant          <= grant_next;
      last           <= last_next;
      first_q        <= first_next;
      MEM_READ       <= mem_read_next;
      MEM_WRITE      <= mem_write_next;
      MEM_ADDR       <= mem_addr_next;
      MEM_WRITEDATA  <= mem_wdata_next;
      INSTR_READDATA <= instr_rdata_next;
      DATA_READDATA  <= data_rdata_next;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a small main-memory model whose
// busywait stays high for a programmable number of cycles after each strobe.
module tb_unified_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          CLK;
  logic          RESET;
  logic          INSTR_READ;
  logic [AW-1:0] INSTR_ADDR;
  logic [DW-1:0] INSTR_READDATA;
  logic          INSTR_BUSYWAIT;
  logic          DATA_READ;
  logic          DATA_WRITE;
  logic [AW-1:0] DATA_ADDR;
  logic [DW-1:0] DATA_WRITEDATA;
  logic [DW-1:0] DATA_READDATA;
  logic          DATA_BUSYWAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WRITEDATA;
  logic [DW-1:0] MEM_READDATA;
  logic          MEM_BUSYWAIT;

  int tests = 0;
  int fails = 0;
  int mem_n = 0;
  int mem_cnt = 0;

  localparam logic [DW-1:0] BLK_I   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] BLK_X1  = 128'h11111111_22222222_33333333_44444444;
  localparam logic [DW-1:0] BLK_X2  = 128'h55555555_66666666_77777777_88888888;
  localparam logic [DW-1:0] BLK_X3  = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
  localparam logic [DW-1:0] BLK_X4  = 128'hF0F0F0F0_0F0F0F0F_F0F0F0F0_0F0F0F0F;
  localparam logic [DW-1:0] BLK_X5  = 128'hCAFEBABE_13579BDF_2468ACE0_FEEDFACE;
  localparam logic [DW-1:0] BLK_DB  = {4{32'hDEADBEEF}};
  localparam logic [DW-1:0] BLK_W2  = {4{32'h5A5AA5A5}};

  unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .INSTR_READ(INSTR_READ), .INSTR_ADDR(INSTR_ADDR),
    .INSTR_READDATA(INSTR_READDATA), .INSTR_BUSYWAIT(INSTR_BUSYWAIT),
    .DATA_READ(DATA_READ), .DATA_WRITE(DATA_WRITE), .DATA_ADDR(DATA_ADDR),
    .DATA_WRITEDATA(DATA_WRITEDATA), .DATA_READDATA(DATA_READDATA),
    .DATA_BUSYWAIT(DATA_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: busy while strobed and fewer than mem_n strobed edges have passed.
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < mem_n);
  always @(posedge CLK) begin
    if (RESET) mem_cnt <= 0;
    else if (MEM_READ || MEM_WRITE) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  // Driver tasks
  task automatic clear_inputs();
    INSTR_READ = 1'b0; INSTR_ADDR = '0;
    DATA_READ = 1'b0; DATA_WRITE = 1'b0; DATA_ADDR = '0; DATA_WRITEDATA = '0;
  endtask

  task automatic do_reset(input int cycles);
    RESET = 1'b1;
    repeat (cycles) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic wait_low(input int sel, input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget && ((sel == 0 && INSTR_BUSYWAIT) || (sel == 1 && DATA_BUSYWAIT) ||
                            (sel == 2 && (MEM_READ || MEM_WRITE)))) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    INSTR_READ = 1'b1; DATA_READ = 1'b1;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    tests++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin fails++; $display("FAIL reset_strobes: got rd=%b wr=%b, want 0 0", MEM_READ, MEM_WRITE); end
    tests++; if (MEM_ADDR !== '0 || MEM_WRITEDATA !== '0) begin fails++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h, want 0", MEM_ADDR, MEM_WRITEDATA); end
    tests++; if (INSTR_READDATA !== '0 || DATA_READDATA !== '0) begin fails++; $display("FAIL reset_readdata: got i=%h d=%h, want 0", INSTR_READDATA, DATA_READDATA); end
    tests++; if (INSTR_BUSYWAIT !== 1'b1 || DATA_BUSYWAIT !== 1'b1) begin fails++; $display("FAIL reset_busywait: got i=%b d=%b, want 1 1", INSTR_BUSYWAIT, DATA_BUSYWAIT); end
    clear_inputs();
    RESET = 1'b0;
    @(negedge CLK);
    tests++; if (dut.state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d, want 0 (IDLE)", dut.state); end
  endtask

  task automatic test_instr_read();
    int cyc;
    mem_n = 4; MEM_READDATA = BLK_I;
    INSTR_READ = 1'b1; INSTR_ADDR = 28'h0000010;
    #1;
    tests++; if (INSTR_BUSYWAIT !== 1'b1 || DATA_BUSYWAIT !== 1'b0) begin fails++; $display("FAIL ird_busy_same_cycle: got i=%b d=%b, want 1 0", INSTR_BUSYWAIT, DATA_BUSYWAIT); end
    @(negedge CLK);
    tests++; if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 || MEM_ADDR !== 28'h10) begin fails++; $display("FAIL ird_grant: got rd=%b wr=%b addr=%h, want 1 0 0000010", MEM_READ, MEM_WRITE, MEM_ADDR); end
    wait_low(0, 20, cyc);
    tests++; if (cyc !== 5) begin fails++; $display("FAIL ird_latency: got %0d cycles, want 5", cyc); end
    tests++; if (INSTR_READDATA !== BLK_I) begin fails++; $display("FAIL ird_data: got %h, want %h", INSTR_READDATA, BLK_I); end
    tests++; if (MEM_READ !== 1'b0 || DATA_BUSYWAIT !== 1'b0) begin fails++; $display("FAIL ird_respond: got rd=%b dbusy=%b, want 0 0", MEM_READ, DATA_BUSYWAIT); end
    INSTR_READ = 1'b0;
    @(negedge CLK);
    tests++; if (dut.state !== 2'd0) begin fails++; $display("FAIL ird_idle: got %0d, want 0", dut.state); end
  endtask

  task automatic test_contention();
    int cyc;
    do_reset(2);
    mem_n = 1; MEM_READDATA = BLK_X1;
    INSTR_READ = 1'b1; INSTR_ADDR = 28'h20;
    DATA_READ = 1'b1;  DATA_ADDR = 28'h30;
    @(negedge CLK);
    tests++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h30) begin fails++; $display("FAIL cont_first_data: got rd=%b addr=%h, want 1 0000030", MEM_READ, MEM_ADDR); end
    wait_low(1, 20, cyc);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL cont_data_latency: got %0d, want 2", cyc); end
    tests++; if (DATA_READDATA !== BLK_X1 || INSTR_BUSYWAIT !== 1'b1) begin fails++; $display("FAIL cont_data_done: got d=%h ibusy=%b, want %h 1", DATA_READDATA, INSTR_BUSYWAIT, BLK_X1); end
    DATA_ADDR = 28'h31;
    @(negedge CLK); @(negedge CLK);
    tests++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h20) begin fails++; $display("FAIL cont_then_instr: got rd=%b addr=%h, want 1 0000020", MEM_READ, MEM_ADDR); end
    MEM_READDATA = BLK_X2;
    wait_low(0, 20, cyc);
    tests++; if (cyc !== 2 || INSTR_READDATA !== BLK_X2) begin fails++; $display("FAIL cont_instr_done: got cyc=%0d i=%h, want 2 %h", cyc, INSTR_READDATA, BLK_X2); end
    tests++; if (DATA_READDATA !== BLK_X1) begin fails++; $display("FAIL cont_data_hold: got %h, want %h", DATA_READDATA, BLK_X1); end
    INSTR_READ = 1'b0;
    @(negedge CLK); @(negedge CLK);
    tests++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h31) begin fails++; $display("FAIL cont_alternate: got rd=%b addr=%h, want 1 0000031", MEM_READ, MEM_ADDR); end
    MEM_READDATA = BLK_X3;
    wait_low(1, 20, cyc);
    tests++; if (cyc !== 2 || DATA_READDATA !== BLK_X3) begin fails++; $display("FAIL cont_data2_done: got cyc=%0d d=%h, want 2 %h", cyc, DATA_READDATA, BLK_X3); end
    DATA_READ = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_write_back();
    int cyc;
    mem_n = 2; MEM_READDATA = BLK_X4;
    DATA_WRITE = 1'b1; DATA_ADDR = 28'h0ABCDEF; DATA_WRITEDATA = BLK_DB;
    @(negedge CLK);
    tests++; if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0 || MEM_ADDR !== 28'h0ABCDEF || MEM_WRITEDATA !== BLK_DB) begin fails++; $display("FAIL wb_grant: got wr=%b rd=%b addr=%h wdata=%h", MEM_WRITE, MEM_READ, MEM_ADDR, MEM_WRITEDATA); end
    DATA_ADDR = '0; DATA_WRITEDATA = '0;
    @(negedge CLK);
    tests++; if (MEM_WRITE !== 1'b1 || MEM_ADDR !== 28'h0ABCDEF || MEM_WRITEDATA !== BLK_DB) begin fails++; $display("FAIL wb_held: got wr=%b addr=%h wdata=%h, want 1 0abcdef %h", MEM_WRITE, MEM_ADDR, MEM_WRITEDATA, BLK_DB); end
    wait_low(1, 20, cyc);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL wb_latency: got %0d, want 2", cyc); end
    tests++; if (DATA_READDATA !== BLK_X3 || MEM_WRITE !== 1'b0) begin fails++; $display("FAIL wb_readdata_kept: got d=%h wr=%b, want %h 0", DATA_READDATA, MEM_WRITE, BLK_X3); end
    DATA_WRITE = 1'b0;
    @(negedge CLK);
    tests++; if (DATA_BUSYWAIT !== 1'b0 || dut.state !== 2'd0) begin fails++; $display("FAIL wb_idle: got dbusy=%b state=%0d, want 0 0", DATA_BUSYWAIT, dut.state); end
  endtask

  task automatic test_read_write_both();
    int cyc;
    mem_n = 0; MEM_READDATA = BLK_X1;
    DATA_READ = 1'b1; DATA_WRITE = 1'b1; DATA_ADDR = 28'h40; DATA_WRITEDATA = BLK_W2;
    @(negedge CLK);
    tests++; if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0 || MEM_WRITEDATA !== BLK_W2) begin fails++; $display("FAIL rw_both: got wr=%b rd=%b wdata=%h, want 1 0 %h", MEM_WRITE, MEM_READ, MEM_WRITEDATA, BLK_W2); end
    wait_low(1, 20, cyc);
    tests++; if (cyc !== 2 || DATA_READDATA !== BLK_X3) begin fails++; $display("FAIL rw_done: got cyc=%0d d=%h, want 2 %h", cyc, DATA_READDATA, BLK_X3); end
    DATA_READ = 1'b0; DATA_WRITE = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_abort();
    int cyc;
    mem_n = 3; MEM_READDATA = BLK_X2;
    INSTR_READ = 1'b1; INSTR_ADDR = 28'h50;
    @(negedge CLK);
    tests++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h50) begin fails++; $display("FAIL abort_grant: got rd=%b addr=%h, want 1 0000050", MEM_READ, MEM_ADDR); end
    INSTR_READ = 1'b0;
    #1;
    tests++; if (INSTR_BUSYWAIT !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b, want 0", INSTR_BUSYWAIT); end
    @(negedge CLK);
    tests++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h50) begin fails++; $display("FAIL abort_held: got rd=%b addr=%h, want 1 0000050", MEM_READ, MEM_ADDR); end
    wait_low(2, 20, cyc);
    tests++; if (cyc !== 3 || dut.state !== 2'd2) begin fails++; $display("FAIL abort_complete: got cyc=%0d state=%0d, want 3 2", cyc, dut.state); end
    @(negedge CLK);
    tests++; if (dut.state !== 2'd0 || MEM_READ !== 1'b0) begin fails++; $display("FAIL abort_idle: got state=%0d rd=%b, want 0 0", dut.state, MEM_READ); end
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    mem_n = 5; MEM_READDATA = BLK_X5;
    INSTR_READ = 1'b1; INSTR_ADDR = 28'h60;
    @(negedge CLK);
    DATA_READ = 1'b1; DATA_ADDR = 28'h70;
    @(negedge CLK);
    tests++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h60 || DATA_BUSYWAIT !== 1'b1) begin fails++; $display("FAIL rst_mid_access: got rd=%b addr=%h dbusy=%b, want 1 0000060 1", MEM_READ, MEM_ADDR, DATA_BUSYWAIT); end
    RESET = 1'b1; INSTR_READ = 1'b0;
    @(negedge CLK);
    tests++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0 || MEM_ADDR !== '0 || dut.state !== 2'd0) begin fails++; $display("FAIL rst_mid_clear: got rd=%b wr=%b addr=%h state=%0d, want 0 0 0 0", MEM_READ, MEM_WRITE, MEM_ADDR, dut.state); end
    tests++; if (DATA_BUSYWAIT !== 1'b1) begin fails++; $display("FAIL rst_mid_dbusy: got %b, want 1", DATA_BUSYWAIT); end
    RESET = 1'b0;
    @(negedge CLK);
    tests++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h70) begin fails++; $display("FAIL rst_mid_regrant: got rd=%b addr=%h, want 1 0000070", MEM_READ, MEM_ADDR); end
    wait_low(1, 20, cyc);
    tests++; if (cyc !== 6 || DATA_READDATA !== BLK_X5) begin fails++; $display("FAIL rst_mid_done: got cyc=%0d d=%h, want 6 %h", cyc, DATA_READDATA, BLK_X5); end
    DATA_READ = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    clear_inputs();
    MEM_READDATA = '0;
    RESET = 1'b1;
    test_reset();
    test_instr_read();
    test_contention();
    test_write_back();
    test_read_write_both();
    test_abort();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
